// File: rtl/t48_timer_multi.sv
// Multi-channel T48 timer/event counter with per-channel reload register and sticky overflow flag.
// Counters, flags and overflow pulses are registered (1 enabled cycle); data_o is combinational; no flow control.
module t48_timer_multi #(
   parameter int CNT_W = 8,
   parameter int PRE_W = 5,
   parameter int CH_N  = 2,
   parameter int CH_W  = 1
) (
   input  logic             clk_i,
   input  logic             res_i,
   input  logic             en_clk_i,
   input  logic [2:0]       clk_mstate_i,
   input  logic [CH_N-1:0]  t_i,
   input  logic [CH_W-1:0]  ch_sel_i,
   input  logic [CNT_W-1:0] data_i,
   input  logic             read_timer_i,
   input  logic             write_timer_i,
   input  logic             write_reload_i,
   input  logic             start_t_i,
   input  logic             start_cnt_i,
   input  logic             stop_tcnt_i,
   input  logic             arld_i,
   input  logic             ovf_clr_i,
   output logic [CNT_W-1:0] data_o,
   output logic [CH_N-1:0]  overflow_o,
   output logic [CH_N-1:0]  ovf_flag_o
);
   typedef enum logic [1:0] {IDLE = 2'b00, TIMER = 2'b01, COUNTER = 2'b10} mode_t;

   mode_t            mode_q [CH_N];
   mode_t            mode_d [CH_N];
   logic [CNT_W-1:0] cnt_q  [CH_N];
   logic [CNT_W-1:0] cnt_d  [CH_N];
   logic [CNT_W-1:0] rld_q  [CH_N];
   logic [CNT_W-1:0] rld_d  [CH_N];
   logic [PRE_W-1:0] pre_q  [CH_N];
   logic [PRE_W-1:0] pre_d  [CH_N];
   logic [CH_N-1:0]  arld_q, arld_d;
   logic [CH_N-1:0]  t_q, t_d;
   logic [CH_N-1:0]  ovf_q, ovf_d;
   logic [CH_N-1:0]  flag_q, flag_d;
   logic [CH_N-1:0]  sel, inc;

   always_comb begin
      sel = '0;
      inc = '0;
      for (int i = 0; i < CH_N; i++) begin
         sel[i] = (ch_sel_i == CH_W'(i));
         inc[i] = (clk_mstate_i == 3'b100) &&
                  (((mode_q[i] == TIMER) && (&pre_q[i])) ||
                   ((mode_q[i] == COUNTER) && t_q[i] && !t_i[i]));
      end
   end

   always_comb begin
      arld_d = arld_q;
      t_d    = t_q;
      ovf_d  = '0;
      flag_d = flag_q;
      for (int i = 0; i < CH_N; i++) begin
         mode_d[i] = mode_q[i];
         pre_d[i]  = pre_q[i];
         cnt_d[i]  = cnt_q[i];
         rld_d[i]  = rld_q[i];

         if (sel[i] && start_t_i) begin
            mode_d[i] = TIMER;
            arld_d[i] = arld_i;
         end else if (sel[i] && start_cnt_i) begin
            mode_d[i] = COUNTER;
            arld_d[i] = arld_i;
         end else if (sel[i] && stop_tcnt_i) begin
            mode_d[i] = IDLE;
         end

         if (sel[i] && start_t_i)
            pre_d[i] = '0;
         else if (clk_mstate_i == 3'b010)
            pre_d[i] = pre_q[i] + PRE_W'(1);

         if (clk_mstate_i == 3'b011)
            t_d[i] = t_i[i];

         // A software write overrides a coincident tick and suppresses its overflow
         if (sel[i] && write_timer_i) begin
            cnt_d[i] = data_i;
         end else if (inc[i]) begin
            if (&cnt_q[i]) begin
               cnt_d[i] = arld_q[i] ? rld_q[i] : '0;
               ovf_d[i] = 1'b1;
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end

         if (sel[i] && write_reload_i)
            rld_d[i] = data_i;

         if (ovf_d[i])
            flag_d[i] = 1'b1;
         else if (sel[i] && ovf_clr_i)
            flag_d[i] = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge res_i) begin
      if (res_i) begin
         for (int i = 0; i < CH_N; i++) begin
            mode_q[i] <= IDLE;
            pre_q[i]  <= '0;
            cnt_q[i]  <= '0;
            rld_q[i]  <= '0;
         end
         arld_q <= '0;
         t_q    <= '0;
         ovf_q  <= '0;
         flag_q <= '0;
      end else if (en_clk_i) begin
         for (int i = 0; i < CH_N; i++) begin
            mode_q[i] <= mode_d[i];
            pre_q[i]  <= pre_d[i];
            cnt_q[i]  <= cnt_d[i];
            rld_q[i]  <= rld_d[i];
         end
         arld_q <= arld_d;
         t_q    <= t_d;
         ovf_q  <= ovf_d;
         flag_q <= flag_d;
      end
   end

   always_comb begin
      data_o = '1;
      for (int i = 0; i < CH_N; i++)
         if (read_timer_i && sel[i])
            data_o = cnt_q[i];
   end

   assign overflow_o = ovf_q;
   assign ovf_flag_o = flag_q;
endmodule

// File: tb/tb_t48_timer_multi.sv
// Directed bench for t48_timer_multi: timer, event counter, wrap/reload, collisions, clock enable, reset.
module tb_t48_timer_multi;
   logic       clk_i = 1'b0;
   logic       res_i = 1'b1;
   logic       en_clk_i = 1'b1;
   logic [2:0] clk_mstate_i = 3'd0;
   logic [1:0] t_i = 2'b00;
   logic [0:0] ch_sel_i = 1'b0;
   logic [7:0] data_i = 8'h00;
   logic       read_timer_i = 1'b0;
   logic       write_timer_i = 1'b0;
   logic       write_reload_i = 1'b0;
   logic       start_t_i = 1'b0;
   logic       start_cnt_i = 1'b0;
   logic       stop_tcnt_i = 1'b0;
   logic       arld_i = 1'b0;
   logic       ovf_clr_i = 1'b0;
   logic [7:0] data_o;
   logic [1:0] overflow_o;
   logic [1:0] ovf_flag_o;

   int vectors = 0;
   int miscompares = 0;
   logic [7:0] rv;

   t48_timer_multi dut (
      .clk_i(clk_i), .res_i(res_i), .en_clk_i(en_clk_i), .clk_mstate_i(clk_mstate_i),
      .t_i(t_i), .ch_sel_i(ch_sel_i), .data_i(data_i), .read_timer_i(read_timer_i),
      .write_timer_i(write_timer_i), .write_reload_i(write_reload_i), .start_t_i(start_t_i),
      .start_cnt_i(start_cnt_i), .stop_tcnt_i(stop_tcnt_i), .arld_i(arld_i),
      .ovf_clr_i(ovf_clr_i), .data_o(data_o), .overflow_o(overflow_o), .ovf_flag_o(ovf_flag_o)
   );

   initial forever #5 clk_i = ~clk_i;

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic rd(input int ch, output logic [7:0] v);
      ch_sel_i = ch[0];
      read_timer_i = 1'b1;
      #1;
      v = data_o;
      read_timer_i = 1'b0;
   endtask

   task automatic mcycles(input int n);
      for (int k = 0; k < n; k++)
         for (int m = 0; m < 5; m++) begin
            clk_mstate_i = m[2:0];
            step();
         end
   endtask

   // mstate 0..3 with t_i[ch] = a (sampled at mstate 3), leaving mstate 4 to the caller
   task automatic ev_pre(input int ch, input logic a);
      t_i[ch] = a;
      for (int m = 0; m < 4; m++) begin
         clk_mstate_i = m[2:0];
         step();
      end
   endtask

   task automatic ev(input int ch, input logic a, input logic b);
      ev_pre(ch, a);
      t_i[ch] = b;
      clk_mstate_i = 3'd4;
      step();
   endtask

   initial begin
      // reset
      step(); step();
      chk("rst_ovf", overflow_o, 2'b00);
      chk("rst_flag", ovf_flag_o, 2'b00);
      #1 chk("rst_data_noread", data_o, 8'hFF);
      rd(0, rv); chk("rst_cnt0", rv, 8'h00);
      res_i = 1'b0;
      step();

      // 1: prescaled timer on ch0
      ch_sel_i = 1'b0; start_t_i = 1'b1; step(); start_t_i = 1'b0;
      mcycles(30);
      rd(0, rv); chk("tmr_before_tick", rv, 8'h00);
      mcycles(1);
      rd(0, rv); chk("tmr_first_tick", rv, 8'h01);
      mcycles(32);
      rd(0, rv); chk("tmr_second_tick", rv, 8'h02);
      rd(1, rv); chk("tmr_ch1_idle", rv, 8'h00);

      // 2: event counter on ch1
      clk_mstate_i = 3'd0;
      ch_sel_i = 1'b0; stop_tcnt_i = 1'b1; step(); stop_tcnt_i = 1'b0;
      ch_sel_i = 1'b1; start_cnt_i = 1'b1; step(); start_cnt_i = 1'b0;
      for (int k = 0; k < 5; k++) begin
         ev(1, 1'b1, 1'b0);
         ev(1, 1'b0, 1'b1);
      end
      ev(1, 1'b1, 1'b1);
      rd(1, rv); chk("cnt_five_falls", rv, 8'h05);
      rd(0, rv); chk("cnt_ch0_stopped", rv, 8'h02);

      // 3: wrap without reload on ch0 (event mode for a quick tick)
      t_i[1] = 1'b0;
      clk_mstate_i = 3'd0;
      ch_sel_i = 1'b0; data_i = 8'hFF; write_timer_i = 1'b1; step(); write_timer_i = 1'b0;
      arld_i = 1'b0; start_cnt_i = 1'b1; step(); start_cnt_i = 1'b0;
      ev(0, 1'b1, 1'b0);
      chk("wrap_ovf_pulse", overflow_o, 2'b01);
      chk("wrap_flag_set", ovf_flag_o, 2'b01);
      rd(0, rv); chk("wrap_cnt_zero", rv, 8'h00);
      clk_mstate_i = 3'd0; step();
      chk("wrap_ovf_one_cycle", overflow_o, 2'b00);
      ch_sel_i = 1'b0; ovf_clr_i = 1'b1; step(); ovf_clr_i = 1'b0;
      chk("wrap_flag_cleared", ovf_flag_o, 2'b00);

      // 4: auto-reload timer on ch0
      ch_sel_i = 1'b0; data_i = 8'hF0; write_reload_i = 1'b1; step(); write_reload_i = 1'b0;
      data_i = 8'hFF; write_timer_i = 1'b1; step(); write_timer_i = 1'b0;
      arld_i = 1'b1; start_t_i = 1'b1; step(); start_t_i = 1'b0; arld_i = 1'b0;
      mcycles(31);
      chk("arld_ovf_pulse", overflow_o, 2'b01);
      chk("arld_flag_set", ovf_flag_o, 2'b01);
      rd(0, rv); chk("arld_cnt_reload", rv, 8'hF0);
      clk_mstate_i = 3'd0;
      ch_sel_i = 1'b0; data_i = 8'hFF; write_timer_i = 1'b1; step(); write_timer_i = 1'b0;
      mcycles(31);
      ev_pre(0, 1'b0);
      clk_mstate_i = 3'd4; ch_sel_i = 1'b0; ovf_clr_i = 1'b1; step(); ovf_clr_i = 1'b0;
      chk("arld_set_beats_clr", ovf_flag_o, 2'b01);
      chk("arld_second_pulse", overflow_o, 2'b01);
      rd(0, rv); chk("arld_second_reload", rv, 8'hF0);
      clk_mstate_i = 3'd0;
      ch_sel_i = 1'b0; stop_tcnt_i = 1'b1; step(); stop_tcnt_i = 1'b0;

      // 5: write vs tick collision on ch1, then start_t vs stop
      ch_sel_i = 1'b1; data_i = 8'hFF; write_timer_i = 1'b1; step(); write_timer_i = 1'b0;
      ev_pre(1, 1'b1);
      t_i[1] = 1'b0; clk_mstate_i = 3'd4;
      ch_sel_i = 1'b1; data_i = 8'h42; write_timer_i = 1'b1; step(); write_timer_i = 1'b0;
      chk("coll_no_ovf", overflow_o, 2'b00);
      chk("coll_flag_ch1_clear", ovf_flag_o, 2'b01);
      rd(1, rv); chk("coll_write_wins", rv, 8'h42);
      clk_mstate_i = 3'd0;
      ch_sel_i = 1'b1; start_t_i = 1'b1; stop_tcnt_i = 1'b1; step();
      start_t_i = 1'b0; stop_tcnt_i = 1'b0;
      ev(1, 1'b1, 1'b0);
      rd(1, rv); chk("start_stop_no_event", rv, 8'h42);
      t_i[1] = 1'b0;
      mcycles(30);
      rd(1, rv); chk("start_stop_is_timer", rv, 8'h43);
      rd(0, rv); chk("coll_ch0_untouched", rv, 8'hF0);

      // 6: clock enable low with ticks present, then asynchronous reset
      en_clk_i = 1'b0;
      mcycles(2);
      rd(1, rv); chk("en_low_hold", rv, 8'h43);
      en_clk_i = 1'b1;
      clk_mstate_i = 3'd4; step();
      rd(1, rv); chk("en_high_tick", rv, 8'h44);
      clk_mstate_i = 3'd2; step(); step();
      res_i = 1'b1;
      #1;
      chk("arst_ovf", overflow_o, 2'b00);
      chk("arst_flag", ovf_flag_o, 2'b00);
      rd(0, rv); chk("arst_cnt0", rv, 8'h00);
      rd(1, rv); chk("arst_cnt1", rv, 8'h00);
      step();
      res_i = 1'b0;
      ev(0, 1'b1, 1'b0);
      ev(1, 1'b1, 1'b0);
      t_i = 2'b00;
      mcycles(32);
      rd(0, rv); chk("idle_after_rst_ch0", rv, 8'h00);
      rd(1, rv); chk("idle_after_rst_ch1", rv, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
